kbd_event_decoder: RTL and testbench

KBD_EVENT_DECODER -- requirements
Module: kbd_event_decoder

---
 rtl/kbd_event_decoder.sv | 121 ++++++++++++
 tb/tb_kbd_event_decoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_decoder.sv
// PS/2 set-2 scancode stream to key-event decoder with held-key tracking and optional typematic filter.
// Optional macro KBD_ASCII_EN adds a main-block ASCII lookup for non-extended presses.
module kbd_event_decoder #(
  parameter int unsigned REPEAT_FILTER = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] evt_ascii,
  output logic [7:0] press_count,
  output logic       held
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, OUT} state_t;

  state_t     state;
  logic [8:0] held_key;

  logic accept_c;
  logic is_noise_c;
  logic cur_ext_c;
  logic cur_brk_c;
  logic key_match_c;
  logic suppress_c;
  logic load_c;

  // Classification of the byte offered in the current cycle.
  assign accept_c    = (state != OUT) && byte_valid;
  assign is_noise_c  = byte_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
  assign cur_ext_c   = (state == EXT) || (state == EXT_BRK);
  assign cur_brk_c   = (state == BRK) || (state == EXT_BRK);
  assign key_match_c = held && (held_key == {cur_ext_c, byte_data});
  assign suppress_c  = (REPEAT_FILTER != 0) && !cur_brk_c && key_match_c;
  assign load_c      = accept_c && !is_noise_c && (byte_data != 8'hE0) &&
                       (byte_data != 8'hF0) && !suppress_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_ready  <= 1'b1;
      evt_valid   <= 1'b0;
      evt_code    <= 8'h00;
      evt_ext     <= 1'b0;
      evt_break   <= 1'b0;
      press_count <= 8'h00;
      held        <= 1'b0;
      held_key    <= 9'h000;
    end else if (state == OUT) begin
      if (evt_ready) begin
        state      <= IDLE;
        evt_valid  <= 1'b0;
        byte_ready <= 1'b1;
      end
    end else if (byte_valid) begin
      if (is_noise_c) begin
        state <= IDLE;
      end else if (byte_data == 8'hE0) begin
        state <= EXT;
      end else if (byte_data == 8'hF0) begin
        state <= cur_ext_c ? EXT_BRK : BRK;
      end else if (suppress_c) begin
        state <= IDLE;
      end else begin
        state      <= OUT;
        evt_valid  <= 1'b1;
        byte_ready <= 1'b0;
        evt_code   <= byte_data;
        evt_ext    <= cur_ext_c;
        evt_break  <= cur_brk_c;
        // Presses claim the held slot; only the matching release frees it.
        if (!cur_brk_c) begin
          press_count <= press_count + 8'd1;
          held        <= 1'b1;
          held_key    <= {cur_ext_c, byte_data};
        end else if (key_match_c) begin
          held <= 1'b0;
        end
      end
    end
  end

`ifdef KBD_ASCII_EN
  function automatic logic [7:0] set2_ascii(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // ASCII is loaded with the rest of the event; releases and extended keys give 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_ascii <= 8'h00;
    end else if (load_c) begin
      evt_ascii <= (cur_ext_c || cur_brk_c) ? 8'h00 : set2_ascii(byte_data);
    end
  end
`else
  assign evt_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Randomized self-checking bench for kbd_event_decoder against a flag-based scancode model.
module tb_kbd_event_decoder;

`ifdef KBD_ASCII_EN
  localparam bit ASC = 1'b1;
`else
  localparam bit ASC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       bv [2];
  logic [7:0] bd [2];
  logic       br [2];
  logic       ev [2];
  logic       er [2];
  logic [7:0] ec [2];
  logic       ee [2];
  logic       eb [2];
  logic [7:0] ea [2];
  logic [7:0] pc [2];
  logic       hd [2];

  int checks = 0;
  int failures = 0;

  // Model state: pending prefix flags, held key, press counter, expected events.
  bit         m_ext  [2];
  bit         m_brk  [2];
  bit         m_held [2];
  logic [8:0] m_key  [2];
  logic [7:0] m_pc   [2];
  logic [17:0] exp0[$], exp1[$], rx0[$], rx1[$];

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46};
  logic [7:0] pool [10] = '{8'h1C, 8'h32, 8'h29, 8'h75, 8'h5A, 8'h16, 8'hE0, 8'hF0, 8'hAA, 8'hFE};

  kbd_event_decoder dut0 (
    .clk(clk), .rst(rst), .byte_valid(bv[0]), .byte_data(bd[0]), .byte_ready(br[0]),
    .evt_valid(ev[0]), .evt_ready(er[0]), .evt_code(ec[0]), .evt_ext(ee[0]),
    .evt_break(eb[0]), .evt_ascii(ea[0]), .press_count(pc[0]), .held(hd[0]));

  kbd_event_decoder #(.REPEAT_FILTER(0)) dut1 (
    .clk(clk), .rst(rst), .byte_valid(bv[1]), .byte_data(bd[1]), .byte_ready(br[1]),
    .evt_valid(ev[1]), .evt_ready(er[1]), .evt_code(ec[1]), .evt_ext(ee[1]),
    .evt_break(eb[1]), .evt_ascii(ea[1]), .press_count(pc[1]), .held(hd[1]));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && ev[0] && er[0]) rx0.push_back({ee[0], eb[0], ec[0], ea[0]});
    if (!rst && ev[1] && er[1]) rx1.push_back({ee[1], eb[1], ec[1], ea[1]});
  end

  function automatic logic [7:0] ascii_of(input logic [7:0] c);
    if (!ASC) return 8'h00;
    for (int i = 0; i < 26; i++) if (c == letter_codes[i]) return 8'(8'h61 + i);
    for (int i = 0; i < 10; i++) if (c == digit_codes[i]) return 8'(8'h30 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_ext[w] = 1'b0; m_brk[w] = 1'b0; m_held[w] = 1'b0; m_key[w] = 9'h000; m_pc[w] = 8'h00;
    end
    exp0.delete(); exp1.delete(); rx0.delete(); rx1.delete();
  endtask

  task automatic clear_q();
    exp0.delete(); exp1.delete(); rx0.delete(); rx1.delete();
  endtask

  task automatic model_byte(input int w, input logic [7:0] b);
    logic [8:0]  k;
    logic [17:0] e;
    if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1}) begin
      m_ext[w] = 1'b0; m_brk[w] = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext[w] = 1'b1; m_brk[w] = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk[w] = 1'b1;
    end else begin
      k = {m_ext[w], b};
      if (!(w == 0 && !m_brk[w] && m_held[w] && m_key[w] == k)) begin
        e = {m_ext[w], m_brk[w], b, (m_ext[w] || m_brk[w]) ? 8'h00 : ascii_of(b)};
        if (w == 0) exp0.push_back(e); else exp1.push_back(e);
        if (!m_brk[w]) begin
          m_pc[w] = m_pc[w] + 8'd1; m_held[w] = 1'b1; m_key[w] = k;
        end else if (m_held[w] && m_key[w] == k) begin
          m_held[w] = 1'b0;
        end
      end
      m_ext[w] = 1'b0; m_brk[w] = 1'b0;
    end
  endtask

  task automatic send(input int w, input logic [7:0] b, input bit rnd);
    bit ok = 1'b0;
    @(negedge clk);
    bv[w] = 1'b1; bd[w] = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      if (br[w]) ok = 1'b1;
      else begin
        @(negedge clk);
        if (rnd) er[w] = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    bv[w] = 1'b0;
    if (ok) model_byte(w, b);
    else begin
      checks++; failures++;
      $display("FAIL byte_accept_timeout dut%0d byte %h never accepted", w, b);
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin bv[w] = 1'b0; er[w] = 1'b1; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (ev[0] !== 1'b0) begin failures++; $display("FAIL rst_evt_valid got %b want 0", ev[0]); end
    checks++; if (ec[0] !== 8'h00) begin failures++; $display("FAIL rst_evt_code got %h want 00", ec[0]); end
    checks++; if ({ee[0], eb[0]} !== 2'b00) begin failures++; $display("FAIL rst_ext_brk got %b want 00", {ee[0], eb[0]}); end
    checks++; if (ea[0] !== 8'h00) begin failures++; $display("FAIL rst_ascii got %h want 00", ea[0]); end
    checks++; if (pc[0] !== 8'h00) begin failures++; $display("FAIL rst_press_count got %h want 00", pc[0]); end
    checks++; if (hd[0] !== 1'b0) begin failures++; $display("FAIL rst_held got %b want 0", hd[0]); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (br[0] !== 1'b1) begin failures++; $display("FAIL rst_byte_ready got %b want 1", br[0]); end
  endtask

  task automatic test_press_release();
    do_reset();
    send(0, 8'h1C, 0); settle();
    checks++; if (pc[0] !== 8'h01) begin failures++; $display("FAIL pr_count_after_press got %h want 01", pc[0]); end
    checks++; if (hd[0] !== 1'b1) begin failures++; $display("FAIL pr_held_after_press got %b want 1", hd[0]); end
    send(0, 8'hF0, 0); send(0, 8'h1C, 0); settle();
    checks++; if (hd[0] !== 1'b0) begin failures++; $display("FAIL pr_held_after_release got %b want 0", hd[0]); end
    checks++;
    if (rx0.size() != 2) begin failures++; $display("FAIL pr_event_count got %0d want 2", rx0.size()); end
    else begin
      checks++; if (rx0[0] !== {1'b0, 1'b0, 8'h1C, ASC ? 8'h61 : 8'h00}) begin failures++; $display("FAIL pr_press_event got %h want %h", rx0[0], {1'b0, 1'b0, 8'h1C, ASC ? 8'h61 : 8'h00}); end
      checks++; if (rx0[1] !== {1'b0, 1'b1, 8'h1C, 8'h00}) begin failures++; $display("FAIL pr_release_event got %h want %h", rx0[1], {1'b0, 1'b1, 8'h1C, 8'h00}); end
    end
    clear_q();
  endtask

  task automatic test_extended();
    do_reset();
    send(0, 8'hE0, 0); send(0, 8'h75, 0); settle();
    send(0, 8'hE0, 0); send(0, 8'hF0, 0); send(0, 8'h75, 0); settle();
    checks++; if (pc[0] !== 8'h01) begin failures++; $display("FAIL ext_press_count got %h want 01", pc[0]); end
    checks++;
    if (rx0.size() != 2) begin failures++; $display("FAIL ext_event_count got %0d want 2", rx0.size()); end
    else begin
      checks++; if (rx0[0] !== {1'b1, 1'b0, 8'h75, 8'h00}) begin failures++; $display("FAIL ext_press_event got %h want %h", rx0[0], {1'b1, 1'b0, 8'h75, 8'h00}); end
      checks++; if (rx0[1] !== {1'b1, 1'b1, 8'h75, 8'h00}) begin failures++; $display("FAIL ext_release_event got %h want %h", rx0[1], {1'b1, 1'b1, 8'h75, 8'h00}); end
    end
    clear_q();
  endtask

  task automatic test_back_pressure();
    bit seen = 1'b0;
    er[0] = 1'b0;
    send(0, 8'h16, 0);
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = ev[0]; end
    checks++; if (!seen) begin failures++; $display("FAIL bp_evt_valid_timeout got 0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (ev[0] !== 1'b1) begin failures++; $display("FAIL bp_valid_held cyc%0d got %b want 1", i, ev[0]); end
      checks++; if (ec[0] !== 8'h16) begin failures++; $display("FAIL bp_code_stable cyc%0d got %h want 16", i, ec[0]); end
      checks++; if (br[0] !== 1'b0) begin failures++; $display("FAIL bp_byte_ready_low cyc%0d got %b want 0", i, br[0]); end
    end
    er[0] = 1'b1;
    @(negedge clk);
    checks++; if (ev[0] !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got %b want 0", ev[0]); end
    checks++; if (br[0] !== 1'b1) begin failures++; $display("FAIL bp_byte_ready_back got %b want 1", br[0]); end
    checks++;
    if (rx0.size() != 1 || exp0.size() != 1) begin failures++; $display("FAIL bp_event_count got %0d want 1", rx0.size()); end
    else begin
      checks++; if (rx0[0] !== exp0[0]) begin failures++; $display("FAIL bp_event got %h want %h", rx0[0], exp0[0]); end
    end
    clear_q();
  endtask

  task automatic test_repeat();
    logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    do_reset();
    for (int w = 0; w < 2; w++) for (int i = 0; i < 5; i++) send(w, seq[i], 0);
    settle();
    checks++; if (pc[0] !== 8'h01) begin failures++; $display("FAIL rep_filter_count got %h want 01", pc[0]); end
    checks++; if (rx0.size() != 2) begin failures++; $display("FAIL rep_filter_events got %0d want 2", rx0.size()); end
    checks++; if (pc[1] !== 8'h03) begin failures++; $display("FAIL rep_nofilter_count got %h want 03", pc[1]); end
    checks++; if (rx1.size() != 4) begin failures++; $display("FAIL rep_nofilter_events got %0d want 4", rx1.size()); end
    checks++; if (hd[1] !== 1'b0) begin failures++; $display("FAIL rep_nofilter_held got %b want 0", hd[1]); end
    clear_q();
  endtask

  task automatic test_noise_reset();
    do_reset();
    send(0, 8'hAA, 0); send(0, 8'hFA, 0); send(0, 8'hE0, 0);
    do_reset();
    send(0, 8'h29, 0); settle();
    checks++; if (pc[0] !== 8'h01) begin failures++; $display("FAIL nz_press_count got %h want 01", pc[0]); end
    checks++;
    if (rx0.size() != 1) begin failures++; $display("FAIL nz_event_count got %0d want 1", rx0.size()); end
    else begin
      checks++; if (rx0[0] !== {1'b0, 1'b0, 8'h29, ASC ? 8'h20 : 8'h00}) begin failures++; $display("FAIL nz_event got %h want %h", rx0[0], {1'b0, 1'b0, 8'h29, ASC ? 8'h20 : 8'h00}); end
    end
    clear_q();
  endtask

  task automatic test_wrap();
    logic [8:0] keys[$];
    int errs = 0;
    for (int x = 0; x < 2; x++)
      for (int c = 1; c < 256; c++)
        if (!(8'(c) inside {8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1, 8'hE0, 8'hF0}) && keys.size() < 256)
          keys.push_back({1'(x), 8'(c)});
    do_reset();
    foreach (keys[k]) begin
      if (keys[k][8]) send(0, 8'hE0, 0);
      send(0, keys[k][7:0], 0);
      if (keys[k][8]) send(0, 8'hE0, 0);
      send(0, 8'hF0, 0);
      send(0, keys[k][7:0], 0);
      if (k == 254) begin
        settle();
        checks++; if (pc[0] !== 8'hFF) begin failures++; $display("FAIL wrap_count_ff got %h want ff", pc[0]); end
      end
    end
    settle();
    checks++; if (pc[0] !== 8'h00) begin failures++; $display("FAIL wrap_count_zero got %h want 00", pc[0]); end
    checks++; if (rx0.size() != 512) begin failures++; $display("FAIL wrap_event_count got %0d want 512", rx0.size()); end
    for (int i = 0; i < rx0.size() && i < exp0.size(); i++) if (rx0[i] !== exp0[i]) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL wrap_events got %0d bad events want 0", errs); end
    clear_q();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(0, pool[$urandom_range(0, 9)], 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    er[0] = 1'b1;
    settle();
    checks++; if (rx0.size() != exp0.size()) begin failures++; $display("FAIL rnd_event_count got %0d want %0d", rx0.size(), exp0.size()); end
    for (int i = 0; i < rx0.size() && i < exp0.size(); i++) begin
      checks++; if (rx0[i] !== exp0[i]) begin failures++; $display("FAIL rnd_event[%0d] got %h want %h", i, rx0[i], exp0[i]); end
    end
    checks++; if (pc[0] !== m_pc[0]) begin failures++; $display("FAIL rnd_press_count got %h want %h", pc[0], m_pc[0]); end
    checks++; if (hd[0] !== m_held[0]) begin failures++; $display("FAIL rnd_held got %b want %b", hd[0], m_held[0]); end
    clear_q();
  endtask

  initial begin
    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin bv[w] = 1'b0; bd[w] = 8'h00; er[w] = 1'b1; end
    test_reset();
    test_press_release();
    test_extended();
    test_back_pressure();
    test_repeat();
    test_noise_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
